sauria_wei_fifo_zd: RTL



---
 rtl/sauria_pkg.sv | 18 +
 rtl/sauria_lane_zero_det.sv | 15 +
 rtl/sauria_wei_fifo_zd.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sauria_pkg.sv
// Shared SAURIA configuration: array geometry and weight FIFO defaults.
// Also holds the push/pop operation encoding used by the FIFO occupancy logic.
package sauria_pkg;

  localparam int Y                  = 8;
  localparam int IB_W               = 8;
  localparam int WEI_FIFO_POSITIONS = 4;
  localparam bit WEI_FIFO_ZD_EN     = 1'b1;
  localparam int WEI_FIFO_AF_TH     = WEI_FIFO_POSITIONS - 1;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sauria_lane_zero_det.sv
// Per-lane zero detector: flags each IB_W-bit lane of a Y-lane word that is all zeros.
// Purely combinational so it can sit on any write path (weight FIFO, ifmap feeder).
module sauria_lane_zero_det #(
  parameter int Y    = 8,
  parameter int IB_W = 8
) (
  input  logic [Y*IB_W-1:0] i_data,
  output logic [Y-1:0]      o_zmask
);

  for (genvar k = 0; k < Y; k++) begin : g_lane
    assign o_zmask[k] = (i_data[k*IB_W +: IB_W] == '0);
  end

endmodule

// File: rtl/sauria_wei_fifo_zd.sv
// First-word fall-through weight FIFO feeding the systolic array Y inputs, with
// write-time zero masks, programmable almost-full, sync flush and sticky error flags.
module sauria_wei_fifo_zd #(
  parameter int Y     = sauria_pkg::Y,
  parameter int IB_W  = sauria_pkg::IB_W,
  parameter int DEPTH = sauria_pkg::WEI_FIFO_POSITIONS,
  parameter bit ZD_EN = sauria_pkg::WEI_FIFO_ZD_EN,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic [CNT_W-1:0]  i_af_th,
  input  logic              i_push,
  input  logic [Y*IB_W-1:0] i_data,
  input  logic              i_pop,
  output logic [Y*IB_W-1:0] o_data,
  output logic [Y-1:0]      o_zmask,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_afull,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_ovf,
  output logic              o_udf
);

  import sauria_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_acc, pop_acc;
  logic              empty, full;
  logic [Y-1:0]      head_zmask;
  logic [Y*IB_W-1:0] mem_q [DEPTH];
  fifo_op_e          op;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push_acc = !i_flush && i_push && (!full || i_pop);
  assign pop_acc  = !i_flush && i_pop && !empty;
  assign op       = fifo_op_e'({push_acc, pop_acc});

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q || (i_push && full && !i_pop);
    udf_d   = udf_q || (i_pop && empty);
    if (push_acc) wptr_d = ptr_inc(wptr_q);
    if (pop_acc)  rptr_d = ptr_inc(rptr_q);
    unique case (op)
      OP_PUSH: count_d = count_q + CNT_W'(1);
      OP_POP:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: storage is deliberately not reset; o_valid qualifies it, and outputs are gated below.
  always_ff @(posedge i_clk) begin
    if (push_acc) mem_q[wptr_q] <= i_data;
  end

  if (ZD_EN) begin : g_zd
    logic [Y-1:0] wr_zmask;
    logic [Y-1:0] zmem_q [DEPTH];

    sauria_lane_zero_det #(
      .Y    (Y),
      .IB_W (IB_W)
    ) u_zero_det (
      .i_data  (i_data),
      .o_zmask (wr_zmask)
    );

    always_ff @(posedge i_clk) begin
      if (push_acc) zmem_q[wptr_q] <= wr_zmask;
    end

    assign head_zmask = zmem_q[rptr_q];
  end else begin : g_no_zd
    assign head_zmask = '0;
  end

  // Gating on valid gives clean zero outputs after reset without clearing the array.
  assign o_data  = empty ? '0 : mem_q[rptr_q];
  assign o_zmask = empty ? '0 : head_zmask;
  assign o_valid = !empty;
  assign o_full  = full;
  assign o_afull = (count_q >= i_af_th);
  assign o_count = count_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

endmodule
